// File: rtl/rs_decode_pkg.sv
// rs_decode_pkg: shared FSM state type and width helpers for the RS decoder input stream path.
// Rev 1.0
`default_nettype none

package rs_decode_pkg;

  typedef enum logic [2:0] {
    READY        = 3'd0,
    STORE_DATA   = 3'd1,
    CATCH_PARITY = 3'd2,
    FEED_DATA    = 3'd3,
    FEED_PARITY  = 3'd4
  } state_e;

  localparam int unsigned SKID_DEPTH = 2;

  // Index width for n entries, never below one bit.
  function automatic int unsigned width_of(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rs_decode_line_buf.sv
// rs_decode_line_buf: 1W1R synchronous line buffer, read latency one cycle, contents not reset.
// Rev 1.0
`default_nettype none

module rs_decode_line_buf #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned DEPTH  = 128,
  parameter int unsigned ADDR_W = 7
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/rs_decode_stream_in_ctrl.sv
// rs_decode_stream_in_ctrl: buffers a request's data lines, then replays each block (data lines + parity) to the line decoder.
// Optional macro RS_DEC_IN_PERF_EN adds a saturating decoder-stall cycle counter. Rev 1.0
`default_nettype none

module rs_decode_stream_in_ctrl
  import rs_decode_pkg::*;
#(
  parameter int unsigned DATA_W          = 256,
  parameter int unsigned LINES_PER_BLOCK = 8,
  parameter int unsigned MAX_BLOCKS      = 16,
  parameter int unsigned BLOCK_CNT_W     = $clog2(MAX_BLOCKS + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   src_stream_decoder_req_val,
  output logic                   stream_decoder_src_req_rdy,
  input  logic [BLOCK_CNT_W-1:0] src_stream_decoder_req_num_blocks,
  input  logic                   src_stream_decoder_req_data_val,
  output logic                   stream_decoder_src_req_data_rdy,
  input  logic [DATA_W-1:0]      src_stream_decoder_req_data,
  output logic                   stream_decode_line_decode_val,
  input  logic                   line_decode_stream_decode_rdy,
  output logic [DATA_W-1:0]      stream_decode_line_decode_data,
  output logic                   stream_decode_line_decode_parity,
  output logic                   stream_decode_line_decode_last_block,
  output logic                   stream_decode_idle
`ifdef RS_DEC_IN_PERF_EN
  , output logic [31:0]          stream_decode_stall_cnt
`endif
);

  localparam int unsigned DEPTH      = MAX_BLOCKS * LINES_PER_BLOCK;
  localparam int unsigned ADDR_W     = width_of(DEPTH);
  localparam int unsigned TOTAL_W    = ADDR_W + 1;
  localparam int unsigned LINE_CNT_W = $clog2(LINES_PER_BLOCK + 1);

  state_e                 state, state_nxt;
  logic                   ready_en;
  logic [BLOCK_CNT_W-1:0] num_blocks_q, blk_idx;
  logic [ADDR_W-1:0]      wr_addr, rd_addr;
  logic [LINE_CNT_W-1:0]  issued, accepted;
  logic [DATA_W-1:0]      parity_q, ram_q;
  logic [DATA_W-1:0]      skid_mem [SKID_DEPTH];
  logic                   skid_wptr, skid_rptr, rd_pend;
  logic [1:0]             skid_cnt, occupancy;
  logic [TOTAL_W-1:0]     total_lines;
  logic                   meta_acc, data_acc, out_acc, feed_val, last_blk;
  logic                   store_done, issue, push, pop;

  assign meta_acc    = src_stream_decoder_req_val && state == READY && ready_en;
  assign data_acc    = src_stream_decoder_req_data_val && (state == STORE_DATA || state == CATCH_PARITY);
  assign feed_val    = (skid_cnt != 2'd0) || rd_pend;
  assign out_acc     = line_decode_stream_decode_rdy &&
                       ((state == FEED_DATA && feed_val) || state == FEED_PARITY);
  assign last_blk    = (blk_idx + BLOCK_CNT_W'(1)) == num_blocks_q;
  assign total_lines = TOTAL_W'(num_blocks_q) * TOTAL_W'(LINES_PER_BLOCK);
  assign store_done  = data_acc && state == STORE_DATA &&
                       ({1'b0, wr_addr} + TOTAL_W'(1)) == total_lines;
  // Read-but-unaccepted lines (skid entries plus the one in flight) are capped at two.
  assign occupancy   = skid_cnt + 2'(rd_pend);
  assign issue       = state == FEED_DATA && issued != LINE_CNT_W'(LINES_PER_BLOCK) &&
                       (occupancy != 2'd2 || out_acc);
  // RAM output bypasses the empty skid when the decoder takes it the cycle it arrives.
  assign push        = rd_pend && !(skid_cnt == 2'd0 && out_acc);
  assign pop         = out_acc && state == FEED_DATA && skid_cnt != 2'd0;

  rs_decode_line_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk   (clk),
    .we    (data_acc && state == STORE_DATA),
    .waddr (wr_addr),
    .wdata (src_stream_decoder_req_data),
    .re    (issue),
    .raddr (rd_addr),
    .rdata (ram_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= READY;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt                            = state;
    stream_decoder_src_req_rdy           = 1'b0;
    stream_decoder_src_req_data_rdy      = 1'b0;
    stream_decode_line_decode_val        = 1'b0;
    stream_decode_line_decode_data       = parity_q;
    stream_decode_line_decode_parity     = 1'b0;
    stream_decode_line_decode_last_block = 1'b0;
    stream_decode_idle                   = 1'b0;
    case (state)
      READY: begin
        stream_decode_idle         = 1'b1;
        stream_decoder_src_req_rdy = ready_en;
        if (meta_acc && src_stream_decoder_req_num_blocks != '0) state_nxt = STORE_DATA;
      end
      STORE_DATA: begin
        stream_decoder_src_req_data_rdy = 1'b1;
        if (store_done) state_nxt = CATCH_PARITY;
      end
      CATCH_PARITY: begin
        stream_decoder_src_req_data_rdy = 1'b1;
        if (data_acc) state_nxt = FEED_DATA;
      end
      FEED_DATA: begin
        stream_decode_line_decode_val        = feed_val;
        stream_decode_line_decode_data       = (skid_cnt != 2'd0) ? skid_mem[skid_rptr] : ram_q;
        stream_decode_line_decode_last_block = last_blk;
        if (out_acc && accepted == LINE_CNT_W'(LINES_PER_BLOCK - 1)) state_nxt = FEED_PARITY;
      end
      FEED_PARITY: begin
        stream_decode_line_decode_val        = 1'b1;
        stream_decode_line_decode_parity     = 1'b1;
        stream_decode_line_decode_last_block = last_blk;
        if (out_acc) state_nxt = last_blk ? READY : CATCH_PARITY;
      end
      default: state_nxt = READY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en     <= 1'b0;
      num_blocks_q <= '0;
      blk_idx      <= '0;
      wr_addr      <= '0;
      rd_addr      <= '0;
      issued       <= '0;
      accepted     <= '0;
      rd_pend      <= 1'b0;
      skid_cnt     <= 2'd0;
      skid_wptr    <= 1'b0;
      skid_rptr    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      rd_pend  <= issue;
      if (meta_acc) begin
        num_blocks_q <= src_stream_decoder_req_num_blocks;
        blk_idx      <= '0;
        wr_addr      <= '0;
      end
      if (data_acc && state == STORE_DATA) wr_addr <= wr_addr + ADDR_W'(1);
      if (data_acc && state == CATCH_PARITY) begin
        rd_addr  <= ADDR_W'(blk_idx) * ADDR_W'(LINES_PER_BLOCK);
        issued   <= '0;
        accepted <= '0;
      end
      if (issue) begin
        rd_addr <= rd_addr + ADDR_W'(1);
        issued  <= issued + LINE_CNT_W'(1);
      end
      if (out_acc && state == FEED_DATA) accepted <= accepted + LINE_CNT_W'(1);
      if (out_acc && state == FEED_PARITY && !last_blk) blk_idx <= blk_idx + BLOCK_CNT_W'(1);
      if (push) skid_wptr <= ~skid_wptr;
      if (pop)  skid_rptr <= ~skid_rptr;
      skid_cnt <= skid_cnt + 2'(push) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (data_acc && state == CATCH_PARITY) parity_q <= src_stream_decoder_req_data;
    if (push) skid_mem[skid_wptr] <= ram_q;
  end

`ifdef RS_DEC_IN_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stream_decode_stall_cnt <= '0;
    else if (meta_acc)
      stream_decode_stall_cnt <= '0;
    else if (stream_decode_line_decode_val && !line_decode_stream_decode_rdy &&
             stream_decode_stall_cnt != '1)
      stream_decode_stall_cnt <= stream_decode_stall_cnt + 32'd1;
  end
`endif

  a_num_blocks_legal: assert property (@(posedge clk) disable iff (!rst_n)
    meta_acc |-> (src_stream_decoder_req_num_blocks <= BLOCK_CNT_W'(MAX_BLOCKS)));

endmodule

`default_nettype wire
